// File: rtl/counter_scheduler_pkg.sv
// Shared types, defaults and helpers for the counter scheduler.
package counter_scheduler_pkg;

  // Default counter width and terminal value substituted for a zero limit.
  localparam int unsigned CntWidthDef     = 8;
  localparam int unsigned DefaultLimitDef = 10;

  // Widest requester vector the scheduler supports.
  localparam int unsigned MaxReq = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // One-hot vector with a single bit set at position index.
  function automatic logic [MaxReq-1:0] onehot(input int unsigned index);
    return MaxReq'(1) << index;
  endfunction

endpackage

// File: rtl/counter_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
module counter_scheduler_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdxW-1:0]    ptr,
  output logic [IdxW-1:0]    owner,
  output logic               valid
);

  logic [IdxW-1:0] cand;

  // Walk from the farthest offset back to ptr so the nearest set bit wins.
  always_comb begin
    owner = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = IdxW'((int'(ptr) + i) % NUM_REQ);
      if (req[cand]) begin
        owner = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_scheduler.sv
// Round-robin sharing of one modulo counter between NUM_REQ requesters.
module counter_scheduler
  import counter_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned CNT_WIDTH     = CntWidthDef,
  parameter int unsigned DEFAULT_LIMIT = DefaultLimitDef
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*CNT_WIDTH-1:0] limit,
  output logic [NUM_REQ-1:0]           grant,
  output logic [CNT_WIDTH-1:0]         count,
  output logic                         busy,
  output logic [NUM_REQ-1:0]           done
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_WIDTH-1:0] DefLimit = CNT_WIDTH'(DEFAULT_LIMIT);

  state_e               state_q, state_d;
  logic [IdxW-1:0]      ptr_q, ptr_d;
  logic [IdxW-1:0]      owner_q, owner_d;
  logic [CNT_WIDTH-1:0] limit_q, limit_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 busy_q, busy_d;

  logic [IdxW-1:0]      arb_owner;
  logic                 arb_valid;
  logic [CNT_WIDTH-1:0] sel_limit;

  counter_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .owner (arb_owner),
    .valid (arb_valid)
  );

  assign sel_limit = limit[arb_owner*CNT_WIDTH +: CNT_WIDTH];

  // Next-state: arbitration in idle, counting in run, single-cycle done pulse.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    limit_d = limit_q;
    count_d = count_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    done_d  = '0;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          state_d = StRun;
          owner_d = arb_owner;
          limit_d = (sel_limit == '0) ? DefLimit : sel_limit;
          count_d = '0;
          grant_d = NUM_REQ'(onehot(int'(arb_owner)));
          busy_d  = 1'b1;
          ptr_d   = (arb_owner == IdxW'(NUM_REQ - 1)) ? '0 : arb_owner + IdxW'(1);
        end
      end
      StRun: begin
        // Abort wins over terminal count when both happen together.
        if (!req[owner_q]) begin
          state_d = StIdle;
          count_d = '0;
          grant_d = '0;
          busy_d  = 1'b0;
        end else if (count_q == limit_q) begin
          state_d = StDone;
          count_d = '0;
          grant_d = '0;
          busy_d  = 1'b0;
          done_d  = NUM_REQ'(onehot(int'(owner_q)));
        end else begin
          count_d = count_q + CNT_WIDTH'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        count_d = '0;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      limit_q <= '0;
      count_q <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      limit_q <= limit_d;
      count_q <= count_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign grant = grant_q;
  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_counter_scheduler.sv
// Directed self-checking bench for counter_scheduler (NUM_REQ=4, CNT_WIDTH=8).
module tb_counter_scheduler;

  logic        clock;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] limit;
  logic [3:0]  grant;
  logic [7:0]  count;
  logic        busy;
  logic [3:0]  done;

  int checks;
  int failures;

  counter_scheduler #(
    .NUM_REQ       (4),
    .CNT_WIDTH     (8),
    .DEFAULT_LIMIT (10)
  ) dut (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .limit (limit),
    .grant (grant),
    .count (count),
    .busy  (busy),
    .done  (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock; outputs are sampled and inputs driven 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [7:0] c,
                         input logic b, input logic [3:0] d);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".busy"},  32'(busy),  32'(b));
    chk({tag, ".done"},  32'(done),  32'(d));
  endtask

  initial begin
    logic [3:0] exp_g;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    req      = 4'b0000;
    limit    = '0;
    tick();
    tick();
    chk_all("reset", 4'b0000, 8'd0, 1'b0, 4'b0000);
    reset = 1'b0;

    // Basic run: requester 0, limit 3.
    limit[7:0] = 8'd3;
    req = 4'b0001;
    tick();
    chk_all("t1.grant", 4'b0001, 8'd0, 1'b1, 4'b0000);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_all("t1.run", 4'b0001, 8'(i), 1'b1, 4'b0000);
    end
    tick();
    chk_all("t1.done", 4'b0000, 8'd0, 1'b0, 4'b0001);
    req = 4'b0000;
    tick();
    chk_all("t1.idle", 4'b0000, 8'd0, 1'b0, 4'b0000);

    // Zero limit falls back to 10: 11 grant cycles.
    limit[7:0] = 8'd0;
    req = 4'b0001;
    tick();
    chk_all("t2.grant", 4'b0001, 8'd0, 1'b1, 4'b0000);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk_all("t2.run", 4'b0001, 8'(i), 1'b1, 4'b0000);
    end
    tick();
    chk_all("t2.done", 4'b0000, 8'd0, 1'b0, 4'b0001);
    req = 4'b0000;
    tick();
    chk_all("t2.idle", 4'b0000, 8'd0, 1'b0, 4'b0000);

    // Full contention after a reset so the pointer restarts at 0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    limit = {8'd2, 8'd2, 8'd2, 8'd2};
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      for (int c = 0; c <= 2; c++) begin
        tick();
        chk_all("t3.run", exp_g, 8'(c), 1'b1, 4'b0000);
      end
      tick();
      chk_all("t3.done", 4'b0000, 8'd0, 1'b0, exp_g);
      if (k == 4) req = 4'b0000;
      tick();
      chk_all("t3.gap", 4'b0000, 8'd0, 1'b0, 4'b0000);
    end

    // Abort owner 2 mid-run; pending requester 1 is served next. Pointer is 1 here.
    limit = {8'd2, 8'd9, 8'd2, 8'd2};
    req = 4'b0100;
    tick();
    chk_all("t4.grant", 4'b0100, 8'd0, 1'b1, 4'b0000);
    req = 4'b0110;
    for (int i = 1; i <= 5; i++) tick();
    chk_all("t4.cnt5", 4'b0100, 8'd5, 1'b1, 4'b0000);
    req = 4'b0010;
    tick();
    chk_all("t4.abort", 4'b0000, 8'd0, 1'b0, 4'b0000);
    tick();
    chk_all("t4.next", 4'b0010, 8'd0, 1'b1, 4'b0000);
    req = 4'b0000;
    tick();
    chk_all("t4.drop", 4'b0000, 8'd0, 1'b0, 4'b0000);

    // Reset mid-run, then pointer is back at 0 so requester 1 wins over 3.
    limit = {8'd2, 8'd2, 8'd2, 8'd9};
    req = 4'b0001;
    tick();
    chk_all("t5.grant", 4'b0001, 8'd0, 1'b1, 4'b0000);
    for (int i = 1; i <= 4; i++) tick();
    chk_all("t5.cnt4", 4'b0001, 8'd4, 1'b1, 4'b0000);
    reset = 1'b1;
    tick();
    chk_all("t5.reset", 4'b0000, 8'd0, 1'b0, 4'b0000);
    reset = 1'b0;
    req = 4'b1010;
    tick();
    chk_all("t5.rr", 4'b0010, 8'd0, 1'b1, 4'b0000);
    req = 4'b0000;
    tick();
    chk_all("t5.drop", 4'b0000, 8'd0, 1'b0, 4'b0000);

    // Abort coincident with terminal count: no done pulse.
    limit = {8'd2, 8'd2, 8'd2, 8'd2};
    req = 4'b0001;
    tick();
    chk_all("t6.grant", 4'b0001, 8'd0, 1'b1, 4'b0000);
    tick();
    tick();
    chk_all("t6.term", 4'b0001, 8'd2, 1'b1, 4'b0000);
    req = 4'b0000;
    tick();
    chk_all("t6.abort", 4'b0000, 8'd0, 1'b0, 4'b0000);
    tick();
    chk_all("t6.idle", 4'b0000, 8'd0, 1'b0, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
